solitaire_move_ctrl: RTL

Move sequencer for the peg-solitaire board store. It initialises the 7x7 English board, accepts move commands over a valid/ready handshake, and reads source, middle and destination cells through a single-port board memory. If the move is legal it writes the three cells and maintains the peg count. It sits between the pin-level input decoder and the board register file in the tile top level.

---
 rtl/solitaire_move_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/solitaire_move_ctrl.sv
// Peg-solitaire move sequencer: initialises the 7x7 English board, then validates and applies jump moves.
// Command latency 2/6/9 cycles (geometry error / occupancy error / legal move); req_ready only in IDLE.
module solitaire_move_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_x,
    input  logic [2:0] req_y,
    input  logic [1:0] req_dir,
    input  logic       new_game,
    output logic [5:0] brd_addr,
    output logic       brd_we,
    output logic       brd_wdata,
    input  logic       brd_rdata,
    output logic [5:0] piece_count,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [3:0] {
        S_RESET, S_INIT, S_IDLE, S_CHECK, S_RD_SRC, S_RD_MID, S_RD_DST,
        S_EVAL, S_WR_SRC, S_WR_MID, S_WR_DST, S_RESULT
    } state_t;

    state_t state, state_nxt;

    logic [2:0] cmd_x, cmd_y, init_x, init_y;
    logic [1:0] cmd_dir;
    logic       src_bit, mid_bit, err_q;
    logic [5:0] count_q;

    logic signed [3:0] dx, dy, sx, sy, mx, my, tx, ty;
    logic              geo_ok, init_last, init_peg, move_ok;

    function automatic logic playable(input logic signed [3:0] x, input logic signed [3:0] y);
        return (x >= 4'sd0) && (x <= 4'sd6) && (y >= 4'sd0) && (y <= 4'sd6) &&
               ((x >= 4'sd2 && x <= 4'sd4) || (y >= 4'sd2 && y <= 4'sd4));
    endfunction

    function automatic logic [5:0] cell_addr(input logic [2:0] x, input logic [2:0] y);
        return 6'(y) * 6'd7 + 6'(x);
    endfunction

    // Mid/destination in 4-bit signed space so off-board steps go negative or past 6
    always_comb begin
        dx = 4'sd0;
        dy = 4'sd0;
        case (cmd_dir)
            2'd0: dy = -4'sd1;
            2'd1: dx = 4'sd1;
            2'd2: dy = 4'sd1;
            default: dx = -4'sd1;
        endcase
        sx = $signed({1'b0, cmd_x});
        sy = $signed({1'b0, cmd_y});
        mx = sx + dx;
        my = sy + dy;
        tx = mx + dx;
        ty = my + dy;
    end

    assign geo_ok    = playable(sx, sy) && playable(mx, my) && playable(tx, ty);
    assign init_last = (init_x == 3'd6) && (init_y == 3'd6);
    assign init_peg  = playable($signed({1'b0, init_x}), $signed({1'b0, init_y})) &&
                       !(init_x == 3'd3 && init_y == 3'd3);
    // Destination data arrives directly on brd_rdata during EVAL
    assign move_ok   = src_bit && mid_bit && !brd_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RESET;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:  state_nxt = S_INIT;
            S_INIT:   if (init_last) state_nxt = S_IDLE;
            S_IDLE: begin
                if (new_game)       state_nxt = S_INIT;
                else if (req_valid) state_nxt = S_CHECK;
            end
            S_CHECK:  state_nxt = geo_ok ? S_RD_SRC : S_RESULT;
            S_RD_SRC: state_nxt = S_RD_MID;
            S_RD_MID: state_nxt = S_RD_DST;
            S_RD_DST: state_nxt = S_EVAL;
            S_EVAL:   state_nxt = move_ok ? S_WR_SRC : S_RESULT;
            S_WR_SRC: state_nxt = S_WR_MID;
            S_WR_MID: state_nxt = S_WR_DST;
            S_WR_DST: state_nxt = S_RESULT;
            S_RESULT: state_nxt = S_IDLE;
            default:  state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_x   <= '0;
            cmd_y   <= '0;
            cmd_dir <= '0;
            init_x  <= '0;
            init_y  <= '0;
            src_bit <= 1'b0;
            mid_bit <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            if (state == S_INIT) begin
                if (init_x == 3'd6) begin
                    init_x <= '0;
                    init_y <= init_y + 3'd1;
                end else begin
                    init_x <= init_x + 3'd1;
                end
                if (init_last) count_q <= 6'd32;
            end else begin
                init_x <= '0;
                init_y <= '0;
            end
            case (state)
                S_IDLE: if (!new_game && req_valid) begin
                    cmd_x   <= req_x;
                    cmd_y   <= req_y;
                    cmd_dir <= req_dir;
                    err_q   <= 1'b0;
                end
                S_CHECK:  if (!geo_ok) err_q <= 1'b1;
                S_RD_MID: src_bit <= brd_rdata;
                S_RD_DST: mid_bit <= brd_rdata;
                S_EVAL:   if (!move_ok) err_q <= 1'b1;
                S_WR_DST: if (count_q != 6'd0) count_q <= count_q - 6'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        brd_addr  = '0;
        brd_we    = 1'b0;
        brd_wdata = 1'b0;
        case (state)
            S_INIT: begin
                brd_addr  = cell_addr(init_x, init_y);
                brd_we    = 1'b1;
                brd_wdata = init_peg;
            end
            S_RD_SRC: brd_addr = cell_addr(cmd_x, cmd_y);
            S_RD_MID: brd_addr = cell_addr(mx[2:0], my[2:0]);
            S_RD_DST: brd_addr = cell_addr(tx[2:0], ty[2:0]);
            S_WR_SRC: begin
                brd_addr = cell_addr(cmd_x, cmd_y);
                brd_we   = 1'b1;
            end
            S_WR_MID: begin
                brd_addr = cell_addr(mx[2:0], my[2:0]);
                brd_we   = 1'b1;
            end
            S_WR_DST: begin
                brd_addr  = cell_addr(tx[2:0], ty[2:0]);
                brd_we    = 1'b1;
                brd_wdata = 1'b1;
            end
            default: ;
        endcase
    end

    assign req_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_RESULT);
    assign err         = (state == S_RESULT) && err_q;
    assign piece_count = count_q;

endmodule
